// File: rtl/cpu_walker_pkg.sv
// Walker state encoding and PTE field layout shared by the page-table walker.
package cpu_walker_pkg;

  typedef enum logic [2:0] {
    IDLE,
    L1_REQ,
    L1_WAIT,
    L0_REQ,
    L0_WAIT,
    FILL,
    FAULT,
    DRAIN
  } walk_state_t;

  localparam int PTE_V_BIT   = 0;
  localparam int PTE_PPN_LSB = 2;
  localparam int PTE_SHIFT   = 2;

endpackage

// File: rtl/cpu_page_walker.sv
// Two-level hardware page-table walker: TLB miss in, one TLB fill or page-fault strobe out.
//
// state   | meaning
// IDLE    | ready for a miss
// L1_REQ  | level-1 PTE read requested, waiting for grant
// L1_WAIT | level-1 PTE read granted, waiting for data
// L0_REQ  | level-0 PTE read requested, waiting for grant
// L0_WAIT | level-0 PTE read granted, waiting for data
// FILL    | tlb_write strobe cycle
// FAULT   | fault strobe cycle
// DRAIN   | walk flushed, discarding the one outstanding read
module cpu_page_walker
  import cpu_walker_pkg::*;
#(
  parameter int VPN_WIDTH  = 16,
  parameter int PPN_WIDTH  = 16,
  parameter int L1_BITS    = 8,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  miss_valid,
  input  logic [VPN_WIDTH-1:0]  miss_vpn,
  output logic                  miss_ready,
  input  logic [ADDR_WIDTH-1:0] ptbr,
  input  logic                  flush,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  tlb_write,
  output logic [VPN_WIDTH-1:0]  tlb_key,
  output logic [PPN_WIDTH-1:0]  tlb_value,
  output logic                  fault,
  output logic [VPN_WIDTH-1:0]  fault_vpn
);

  localparam int L0_BITS = VPN_WIDTH - L1_BITS;

  walk_state_t          state;
  logic [VPN_WIDTH-1:0] vpn_q;

  logic [ADDR_WIDTH-1:0] l1_addr;
  logic [ADDR_WIDTH-1:0] l0_addr;
  logic                  pte_v;
  logic [PPN_WIDTH-1:0]  pte_ppn;
  logic                  unused_rdata;

  // PTE decode; the level-0 address is formed straight from the level-1 response
  assign l1_addr = ptbr + ADDR_WIDTH'({miss_vpn[VPN_WIDTH-1 -: L1_BITS], {PTE_SHIFT{1'b0}}});
  assign l0_addr = {mem_rdata[ADDR_WIDTH-1:PTE_SHIFT], {PTE_SHIFT{1'b0}}}
                 + ADDR_WIDTH'({vpn_q[L0_BITS-1:0], {PTE_SHIFT{1'b0}}});
  assign pte_v        = mem_rdata[PTE_V_BIT];
  assign pte_ppn      = mem_rdata[PTE_PPN_LSB +: PPN_WIDTH];
  assign unused_rdata = ^mem_rdata;

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      vpn_q      <= '0;
      miss_ready <= 1'b1;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      tlb_write  <= 1'b0;
      tlb_key    <= '0;
      tlb_value  <= '0;
      fault      <= 1'b0;
      fault_vpn  <= '0;
    end else begin
      tlb_write <= 1'b0;
      fault     <= 1'b0;
      case (state)
        IDLE: begin
          if (miss_valid) begin
            vpn_q      <= miss_vpn;
            mem_addr   <= l1_addr;
            mem_req    <= 1'b1;
            miss_ready <= 1'b0;
            state      <= L1_REQ;
          end
        end
        L1_REQ, L0_REQ: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            if (flush)                state <= DRAIN;
            else if (state == L1_REQ) state <= L1_WAIT;
            else                      state <= L0_WAIT;
          end else if (flush) begin
            mem_req    <= 1'b0;
            miss_ready <= 1'b1;
            state      <= IDLE;
          end
        end
        L1_WAIT: begin
          if (mem_rvalid) begin
            if (flush) begin
              miss_ready <= 1'b1;
              state      <= IDLE;
            end else if (!pte_v) begin
              fault     <= 1'b1;
              fault_vpn <= vpn_q;
              state     <= FAULT;
            end else begin
              mem_addr <= l0_addr;
              mem_req  <= 1'b1;
              state    <= L0_REQ;
            end
          end else if (flush) begin
            state <= DRAIN;
          end
        end
        L0_WAIT: begin
          if (mem_rvalid) begin
            if (flush) begin
              miss_ready <= 1'b1;
              state      <= IDLE;
            end else if (!pte_v) begin
              fault     <= 1'b1;
              fault_vpn <= vpn_q;
              state     <= FAULT;
            end else begin
              tlb_write <= 1'b1;
              tlb_key   <= vpn_q;
              tlb_value <= pte_ppn;
              state     <= FILL;
            end
          end else if (flush) begin
            state <= DRAIN;
          end
        end
        FILL, FAULT: begin
          miss_ready <= 1'b1;
          state      <= IDLE;
        end
        DRAIN: begin
          if (mem_rvalid) begin
            miss_ready <= 1'b1;
            state      <= IDLE;
          end
        end
        default: begin
          mem_req    <= 1'b0;
          miss_ready <= 1'b1;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule
